// File: rtl/fir_dsp_pkg.sv
// Shared constants and the round-half-up / saturate helper for the
// decimating FIR datapath.
//   FIR_SUM_W : width of the signed accumulated FIR sum
//   SAMPLE_W  : width of the output sample
//   PHASE_NUM : polyphase count (decimation factor)
//   PHASE_BIT : bits needed to count PHASE_NUM phases
package fir_dsp_pkg;

   localparam int unsigned FIR_SUM_W = 23;
   localparam int unsigned SAMPLE_W  = 8;
   localparam int unsigned PHASE_NUM = 8;
   localparam int unsigned PHASE_BIT = 3;

   // Saturation limits held at sum width + 1 so comparisons never wrap.
   localparam logic signed [FIR_SUM_W:0] Q_MAX = (FIR_SUM_W+1)'(2**(SAMPLE_W-1) - 1);
   localparam logic signed [FIR_SUM_W:0] Q_MIN = ~Q_MAX;

   typedef struct packed {
      logic                sat_hit;
      logic [SAMPLE_W-1:0] sample;
   } rs_result_t;

   // Round half-up by adding half an LSB before the arithmetic shift, then clamp.
   function automatic rs_result_t round_sat(input logic signed [FIR_SUM_W-1:0] x,
                                            input int unsigned               shift);
      logic signed [FIR_SUM_W:0] sum;
      logic signed [FIR_SUM_W:0] q;
      rs_result_t                r;
      sum       = (FIR_SUM_W+1)'(x) + ((FIR_SUM_W+1)'(1) << (shift - 1));
      q         = sum >>> shift;
      r.sat_hit = 1'b0;
      r.sample  = q[SAMPLE_W-1:0];
      if (q > Q_MAX) begin
         r.sat_hit = 1'b1;
         r.sample  = Q_MAX[SAMPLE_W-1:0];
      end else if (q < Q_MIN) begin
         r.sat_hit = 1'b1;
         r.sample  = Q_MIN[SAMPLE_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/dsink_fifo.sv
// Synchronous show-ahead FIFO. The head entry is kept in a register so dout
// holds its last value while the FIFO is empty.
//   clk, rst : clock, synchronous active-high reset
//   wr_en/din: write request and data (dropped when full unless reading)
//   rd_en    : pop the head entry (ignored when empty)
//   dout     : head entry, valid while !empty
//   empty/full/count : occupancy status
module dsink_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [W-1:0]               din,
   input  logic                       rd_en,
   output logic [W-1:0]               dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_nxt;
   logic [CW-1:0] count_nxt;
   logic [W-1:0]  head_nxt;
   logic          rd_ok;
   logic          wr_ok;

   // Accept/advance decisions and the head value after this edge.
   always_comb begin
      rd_ok      = rd_en & ~empty;
      wr_ok      = wr_en & (~full | rd_ok);
      count_nxt  = count + CW'(wr_ok) - CW'(rd_ok);
      rd_ptr_nxt = rd_ptr + AW'(rd_ok);
      head_nxt   = mem[rd_ptr_nxt];
      // The new head is the word being written when it lands in the head slot.
      if (wr_ok && (wr_ptr == rd_ptr_nxt)) begin
         head_nxt = din;
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers, occupancy and registered head.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         dout   <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr_ok);
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         empty  <= (count_nxt == '0);
         full   <= (count_nxt == CW'(DEPTH));
         if (count_nxt != '0) begin
            dout <= head_nxt;
         end
      end
   end

endmodule

// File: rtl/fir_decim_sink.sv
// Decimating sink for the polyphase FIR: keeps one accumulated sum per DECIM
// valid inputs, rounds/saturates it to OUT_W bits and buffers it for a
// valid/ready consumer.
//   clk, rst             : clock, synchronous active-high reset
//   din, din_valid       : full-rate signed FIR sum
//   dout, dout_valid     : show-ahead output stream
//   dout_ready           : consumer accept
//   sat_flag, ovf_flag   : sticky saturation / dropped-sample flags
//   fill                 : FIFO occupancy
//   clr_flags            : clears the sticky flags
module fir_decim_sink
   import fir_dsp_pkg::*;
#(
   parameter int unsigned IN_W       = FIR_SUM_W,
   parameter int unsigned OUT_W      = SAMPLE_W,
   parameter int unsigned SHIFT      = IN_W - OUT_W,
   parameter int unsigned DECIM      = PHASE_NUM,
   parameter int unsigned PHASE_SEL  = 7,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter bit          OFFSET_BIN = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [IN_W-1:0]        din,
   input  logic                          din_valid,
   output logic [OUT_W-1:0]              dout,
   output logic                          dout_valid,
   input  logic                          dout_ready,
   output logic                          sat_flag,
   output logic                          ovf_flag,
   output logic [$clog2(FIFO_DEPTH):0]   fill,
   input  logic                          clr_flags
);

   localparam int unsigned PH_W = $clog2(DECIM);

   logic [PH_W-1:0]        phase;
   logic                   keep;
   logic signed [IN_W-1:0] din_reg;
   logic                   s1_valid;
   rs_result_t             rs;
   logic [OUT_W-1:0]       sample;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic                   rd_ok;
   logic                   drop;

   assign keep = din_valid && (phase == PH_W'(PHASE_SEL));

   // Phase counter; DECIM is a power of two so the wrap is natural.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= '0;
      end else if (din_valid) begin
         phase <= phase + PH_W'(1);
      end
   end

   // Stage 0: capture the kept sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         din_reg  <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= keep;
         if (keep) begin
            din_reg <= din;
         end
      end
   end

   // Stage 1: round, saturate and optionally convert to offset binary.
   always_comb begin
      rs     = round_sat(FIR_SUM_W'(din_reg), SHIFT);
      sample = OUT_W'(rs.sample);
      if (OFFSET_BIN) begin
         sample[OUT_W-1] = ~sample[OUT_W-1];
      end
   end

   // Stage 2: write into the output buffer.
   dsink_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (OUT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (s1_valid),
      .din   (sample),
      .rd_en (dout_ready),
      .dout  (dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fill)
   );

   assign dout_valid = ~fifo_empty;
   assign rd_ok      = dout_ready & ~fifo_empty;
   // A full FIFO only refuses the write when nothing leaves the same cycle.
   assign drop       = s1_valid & fifo_full & ~rd_ok;

   // Sticky flags; a same-cycle set wins over clr_flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_flag <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         if (s1_valid && rs.sat_hit) begin
            sat_flag <= 1'b1;
         end else if (clr_flags) begin
            sat_flag <= 1'b0;
         end
         if (drop) begin
            ovf_flag <= 1'b1;
         end else if (clr_flags) begin
            ovf_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_decim_sink.sv
// Self-checking bench for fir_decim_sink: directed rounding/saturation cases,
// ramp/phase and gap checks, random traffic against an arithmetic model,
// overflow and mid-stream reset.
module tb_fir_decim_sink;

   logic               clk;
   logic               rst;
   logic signed [22:0] din;
   logic               din_valid;
   logic signed [7:0]  dout;
   logic               dout_valid;
   logic               dout_ready;
   logic               sat_flag;
   logic               ovf_flag;
   logic [4:0]         fill;
   logic               clr_flags;

   int total = 0;
   int bad   = 0;

   logic signed [7:0] q[$];
   int vin       = 0;
   int n_acc     = 0;
   int first_out = 999;
   int last_out  = 999;
   bit exp_sat   = 1'b0;
   bit exp_ovf   = 1'b0;

   fir_decim_sink dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .sat_flag   (sat_flag),
      .ovf_flag   (ovf_flag),
      .fill       (fill),
      .clr_flags  (clr_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference: round half-up of x / 2^15, clamped to the signed 8-bit range.
   function automatic logic signed [7:0] model_out(input int x, output bit clamped);
      real y;
      int  v;
      y       = $floor((real'(x) + 16384.0) / 32768.0);
      v       = int'(y);
      clamped = 1'b0;
      if (v > 127) begin
         v = 127;
         clamped = 1'b1;
      end else if (v < -128) begin
         v = -128;
         clamped = 1'b1;
      end
      return 8'(v);
   endfunction

   // One clock: drive inputs, score any handshake, feed the model.
   task automatic step(input int d, input bit v, input bit r);
      logic signed [7:0] e;
      bit                cl;
      din        = 23'(d);
      din_valid  = v;
      dout_ready = r;
      if (dout_valid && r) begin
         chk("out_avail", 32'(q.size() > 0), 32'(1));
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("dout", 32'(dout), 32'(e));
         end
         if (n_acc == 0) first_out = int'(dout);
         last_out = int'(dout);
         n_acc++;
      end
      if (v) begin
         if (vin % 8 == 7) begin
            e = model_out(d, cl);
            q.push_back(e);
            if (cl) exp_sat = 1'b1;
         end
         vin++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      din_valid  = 1'b0;
      dout_ready = 1'b0;
      clr_flags  = 1'b0;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      q.delete();
      vin     = 0;
      exp_sat = 1'b0;
      exp_ovf = 1'b0;
   endtask

   task automatic clr_pulse();
      clr_flags = 1'b1;
      step(0, 1'b0, 1'b1);
      clr_flags = 1'b0;
      exp_sat   = 1'b0;
      exp_ovf   = 1'b0;
   endtask

   task automatic drain();
      repeat (40) step(0, 1'b0, 1'b1);
      chk("drain_valid", 32'(dout_valid), 32'(0));
      chk("drain_model", 32'(q.size()), 32'(0));
   endtask

   int round_in [4] = '{98304, 114688, -16384, -49152};
   int round_out[4] = '{3, 4, 0, -1};
   int sat_in   [2] = '{4194303, -4194304};
   int sat_out  [2] = '{127, -128};

   initial begin
      int first_n;
      int x;
      din       = '0;
      din_valid = 1'b0;
      dout_ready = 1'b0;
      clr_flags = 1'b0;
      rst       = 1'b0;

      // Reset state.
      do_reset();
      chk("rst_dout", 32'(dout), 32'(0));
      chk("rst_valid", 32'(dout_valid), 32'(0));
      chk("rst_fill", 32'(fill), 32'(0));
      chk("rst_sat", 32'(sat_flag), 32'(0));
      chk("rst_ovf", 32'(ovf_flag), 32'(0));

      // Rounding: one burst of 8 per case.
      for (int i = 0; i < 4; i++) begin
         last_out = 999;
         repeat (8) step(round_in[i], 1'b1, 1'b1);
         repeat (3) step(0, 1'b0, 1'b1);
         chk($sformatf("round_%0d", i), 32'(last_out), 32'(round_out[i]));
         chk("round_sat", 32'(sat_flag), 32'(0));
      end

      // Saturation and flag clear.
      for (int i = 0; i < 2; i++) begin
         last_out = 999;
         repeat (8) step(sat_in[i], 1'b1, 1'b1);
         repeat (3) step(0, 1'b0, 1'b1);
         chk($sformatf("sat_%0d", i), 32'(last_out), 32'(sat_out[i]));
         chk("sat_flag", 32'(sat_flag), 32'(exp_sat));
      end
      chk("sat_flag_set", 32'(sat_flag), 32'(1));
      clr_pulse();
      chk("sat_clr", 32'(sat_flag), 32'(0));

      // Ramp from reset: first valid output timing and decimation phase.
      do_reset();
      first_n = 0;
      for (int n = 1; n <= 16; n++) begin
         step(vin * 32768, 1'b1, 1'b1);
         if (first_n == 0 && dout_valid) first_n = n;
      end
      chk("first_valid_cycle", 32'(first_n), 32'(9));

      // Ramp continues with random 5-cycle din_valid gaps.
      while (vin < 120) begin
         if ($urandom_range(0, 9) == 0) begin
            repeat (5) step(int'($urandom_range(0, 4000000)), 1'b0, 1'b1);
         end
         step(vin * 32768, 1'b1, 1'b1);
      end
      drain();
      chk("ramp_last", 32'(last_out), 32'(119));

      // Random traffic with random backpressure.
      clr_pulse();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 1) == 1)
            x = int'($urandom_range(0, 8388607)) - 4194304;
         else
            x = int'($urandom_range(0, 8000000)) - 4000000;
         step(x, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
      end
      drain();
      chk("rand_sat", 32'(sat_flag), 32'(exp_sat));
      chk("rand_ovf", 32'(ovf_flag), 32'(0));

      // Overflow: 20 kept samples with the consumer stalled.
      clr_pulse();
      repeat (160) step(int'($urandom_range(0, 8000000)) - 4000000, 1'b1, 1'b0);
      repeat (3) step(0, 1'b0, 1'b0);
      repeat (4) void'(q.pop_back());
      exp_ovf = 1'b1;
      chk("ovf_fill", 32'(fill), 32'(16));
      chk("ovf_flag", 32'(ovf_flag), 32'(exp_ovf));
      chk("ovf_valid", 32'(dout_valid), 32'(1));
      n_acc = 0;
      repeat (25) step(0, 1'b0, 1'b1);
      chk("ovf_count", 32'(n_acc), 32'(16));
      chk("ovf_empty", 32'(dout_valid), 32'(0));
      chk("ovf_model", 32'(q.size()), 32'(0));

      // Reset with 5 samples buffered.
      repeat (40) step(int'($urandom_range(0, 8000000)) - 4000000, 1'b1, 1'b0);
      repeat (2) step(0, 1'b0, 1'b0);
      chk("pre_rst_fill", 32'(fill), 32'(5));
      chk("pre_rst_ovf", 32'(ovf_flag), 32'(1));
      do_reset();
      chk("mid_rst_valid", 32'(dout_valid), 32'(0));
      chk("mid_rst_fill", 32'(fill), 32'(0));
      chk("mid_rst_sat", 32'(sat_flag), 32'(exp_sat));
      chk("mid_rst_ovf", 32'(ovf_flag), 32'(exp_ovf));
      n_acc     = 0;
      first_out = 999;
      repeat (12) step(vin * 32768, 1'b1, 1'b1);
      repeat (4) step(0, 1'b0, 1'b1);
      chk("post_rst_first", 32'(first_out), 32'(7));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_decim_sink.md
Name: fir_decim_sink

Overview:
- Downstream stage of the 8-phase polyphase decimating FIR.
- Consumes the full-rate 23-bit signed accumulated sum and keeps one sample per DECIM input cycles, at a fixed phase.
- Each kept sample is rounded half-up and saturated to 8 bits, then buffered in a small FIFO.
- Presents a valid/ready stream to the next consumer (DAC formatter or UART packer) and reports sticky saturation and overflow flags.

Parameters:
- IN_W, 23, width of the signed accumulated FIR sum.
- OUT_W, 8, width of the output sample.
- SHIFT, 15, right-shift that removes filter gain (IN_W - OUT_W).
- DECIM, 8, decimation factor; must be a power of 2.
- PHASE_SEL, 7, phase counter value at which a sample is kept (0..DECIM-1).
- FIFO_DEPTH, 16, output buffer depth; must be a power of 2.
- OFFSET_BIN, 0, 1 = invert output MSB (offset-binary for DAC), 0 = two's complement.

Ports:
- clk  in  1  system clock, same as the FIR accumulator.
- rst  in  1  synchronous, active-high reset.
- din  in  IN_W  signed accumulated FIR output.
- din_valid  in  1  din is valid this cycle; the phase counter advances only when high.
- dout  out  OUT_W  head-of-FIFO sample, show-ahead.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer accepts dout when valid && ready.
- sat_flag  out  1  sticky: a kept sample was saturated.
- ovf_flag  out  1  sticky: a kept sample was dropped because the FIFO was full.
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- clr_flags  in  1  clears sat_flag and ovf_flag.

Behaviour:
- Reset values (rst high at a clk edge):
  - phase counter = 0, pipeline valid = 0, FIFO empty.
  - dout = 0, dout_valid = 0, sat_flag = 0, ovf_flag = 0, fill = 0.
  - Reset mid-operation discards all buffered data; the first kept sample after reset is the PHASE_SEL-th valid input, counting from 0.
- Phase counter:
  - Increments modulo DECIM on each din_valid; wraps DECIM-1 -> 0.
  - Holds when din_valid is low.
- Keep (stage 0): when din_valid && phase == PHASE_SEL, register din (signed) and set s1_valid for one cycle.
- Round/saturate (stage 1, combinational on the stage-0 register):
  - sum = din_reg + 2^(SHIFT-1), computed at IN_W+1 bits; no wrap.
  - q = sum >>> SHIFT (arithmetic shift).
  - If q > 2^(OUT_W-1)-1, result = 127 and sat_hit = 1.
  - If q < -2^(OUT_W-1), result = -128 and sat_hit = 1.
  - Otherwise result = q[OUT_W-1:0].
  - If OFFSET_BIN = 1, invert the result MSB.
- Write (stage 2): on s1_valid, attempt a FIFO write at the next edge.
  - Latency: din edge -> stage-0 register -> FIFO write -> dout_valid high = 2 cycles after the keeping edge when the FIFO was empty.
- FIFO full:
  - A write attempt while fill == FIFO_DEPTH and no read this cycle drops the new sample, sets ovf_flag, and leaves FIFO contents unchanged.
  - Simultaneous read and write while full succeeds: fill stays unchanged, no ovf.
- FIFO empty: dout_valid = 0 and dout holds its last value; dout_ready is ignored.
- Simultaneous read and write when empty: the write lands; no bypass, so dout_valid rises next cycle.
- Flags:
  - sat_flag is set on any stage-1 sat_hit with s1_valid, including samples later dropped.
  - clr_flags has priority below a same-cycle set: the flag remains set.
- The consumer may hold dout_ready low indefinitely; dout and dout_valid stay stable until accepted.

Decomposition:
- Shared package fir_dsp_pkg holds:
  - constants FIR_SUM_W = 23, SAMPLE_W = 8, PHASE_NUM = 8, PHASE_BIT = 3;
  - a round/saturate function (signed in, width params).
- One sub-module, dsink_fifo: synchronous show-ahead FIFO with DEPTH and W parameters, ports wr_en/din/rd_en/dout/empty/full/count.
- The phase counter and round/saturate pipeline stay in the top level.

Test Plan:
- Rounding, one din_valid burst of 8 per case, din held for the whole burst:
  - din = 98304 (3.0) -> dout = 3;
  - din = 114688 (3.5) -> dout = 4;
  - din = -16384 (-0.5) -> dout = 0;
  - din = -49152 (-1.5) -> dout = -1.
  - sat_flag stays 0 throughout.
- Saturation: din = 4194303 -> dout = 127, sat_flag = 1. din = -4194304 -> dout = -128. clr_flags pulse -> sat_flag = 0.
- Decimation phase: din = ramp 0,32768,65536,... (k*32768), din_valid always high -> dout sequence 7,15,23,...; first dout_valid rises exactly 9 clk after rst is released.
- din_valid gaps: deassert din_valid for 5 cycles at random points -> the kept-sample sequence is identical to the gap-free run (phase counter does not advance).
- Backpressure/overflow: dout_ready = 0 for 20 kept samples -> fill saturates at 16, ovf_flag = 1, the first 16 values come out in order once ready = 1, and samples 17-20 are absent.
- Reset mid-stream with 5 samples buffered -> next cycle dout_valid = 0, fill = 0, flags = 0; the first output after reset corresponds to the 8th valid input after reset.
